// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Read data returned on a timed-out transaction; sliced to the data width.
    localparam logic [1023:0] TIMEOUT_RD_DATA = '1;

endpackage

// File: rtl/one_hot_mux.sv
// AND-OR multiplexer for a one-hot select over N packed W-bit slices.
module one_hot_mux #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] din,
    output logic [W-1:0]   dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) dout |= din[i*W +: W];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic hit;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!hit && req[cand]) begin
                hit         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling REQ_CNT requesters onto one memory port,
// one transaction at a time, with an optional completion timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int REQ_CNT        = 4,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int IW            = $clog2(REQ_CNT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REQ_CNT-1:0]                req_vld,
    input  logic [REQ_CNT-1:0]                wr_en,
    input  logic [REQ_CNT-1:0]                rd_en,
    input  logic [REQ_CNT*MEM_ADDR_WIDTH-1:0] addr,
    input  logic [REQ_CNT*MEM_DATA_WIDTH-1:0] wr_data,
    output logic [REQ_CNT-1:0]                ack_vld,
    output logic [MEM_DATA_WIDTH-1:0]         rd_data,
    output logic                              mem_req_vld,
    input  logic                              mem_ack_vld,
    output logic [MEM_ADDR_WIDTH-1:0]         mem_addr,
    output logic                              mem_wr_en,
    output logic                              mem_rd_en,
    output logic [MEM_DATA_WIDTH-1:0]         mem_wr_data,
    input  logic [MEM_DATA_WIDTH-1:0]         mem_rd_data,
    output logic [IW-1:0]                     grant_id,
    output logic                              busy,
    output logic                              err_timeout
);

    localparam int PW = MEM_ADDR_WIDTH + MEM_DATA_WIDTH + 2;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_e               state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        gid_q;
    logic [CW-1:0]        cnt;
    logic [PW-1:0]        pay_q;
    logic [REQ_CNT*PW-1:0] pay_all;
    logic [PW-1:0]        pay_sel;
    logic [REQ_CNT-1:0]   win_grant;
    logic [IW-1:0]        win_idx;
    logic [IW-1:0]        next_ptr;
    logic                 tmo_hit;
    logic                 in_busy;
    logic                 done;

    // Payload per requester: {wr_en, rd_en, addr, wr_data}.
    for (genvar i = 0; i < REQ_CNT; i++) begin : g_pay
        assign pay_all[i*PW +: PW] = {wr_en[i], rd_en[i],
                                      addr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH],
                                      wr_data[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH]};
    end

    rr_arbiter #(.N(REQ_CNT), .IW(IW)) u_rr (
        .req   (req_vld),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx)
    );

    one_hot_mux #(.N(REQ_CNT), .W(PW)) u_mux (
        .sel  (win_grant),
        .din  (pay_all),
        .dout (pay_sel)
    );

    assign next_ptr = (win_idx == IW'(REQ_CNT - 1)) ? '0 : win_idx + 1'b1;
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            gid_q <= '0;
            cnt   <= '0;
            pay_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_vld) begin
                        state <= ST_BUSY;
                        gid_q <= win_idx;
                        ptr   <= next_ptr;
                        pay_q <= pay_sel;
                        cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ack_vld || tmo_hit) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is asserted, even mid-transaction.
    assign in_busy     = (state == ST_BUSY) && !rst;
    assign done        = in_busy && (mem_ack_vld || tmo_hit);
    assign busy        = in_busy;
    assign mem_req_vld = in_busy;
    assign mem_wr_en   = in_busy && pay_q[PW-1];
    assign mem_rd_en   = in_busy && pay_q[PW-2];
    assign mem_addr    = rst ? '0 : pay_q[MEM_DATA_WIDTH +: MEM_ADDR_WIDTH];
    assign mem_wr_data = rst ? '0 : pay_q[MEM_DATA_WIDTH-1:0];
    assign grant_id    = rst ? '0 : gid_q;
    assign err_timeout = in_busy && tmo_hit && !mem_ack_vld;

    always_comb begin
        ack_vld = '0;
        rd_data = '0;
        if (done) begin
            ack_vld[gid_q] = 1'b1;
            rd_data = mem_ack_vld ? mem_rd_data : TIMEOUT_RD_DATA[MEM_DATA_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized transaction-level checks of mem_arbiter.
module tb_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_vld = '0, wr_en = '0, rd_en = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wr_data = '0;
    logic [N-1:0]    ack_vld;
    logic [DW-1:0]   rd_data;
    logic            mem_req_vld;
    logic            mem_ack_vld = 1'b0;
    logic [AW-1:0]   mem_addr;
    logic            mem_wr_en, mem_rd_en;
    logic [DW-1:0]   mem_wr_data;
    logic [DW-1:0]   mem_rd_data = '0;
    logic [1:0]      grant_id;
    logic            busy, err_timeout;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.REQ_CNT(N), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wr_data(wr_data), .ack_vld(ack_vld), .rd_data(rd_data),
        .mem_req_vld(mem_req_vld), .mem_ack_vld(mem_ack_vld), .mem_addr(mem_addr),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first requester at or after the model pointer.
    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic idle_checks(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_mreq"}, 64'(mem_req_vld), 64'(0));
        chk({tag, "_ack"},  64'(ack_vld), 64'(0));
        chk({tag, "_rd"},   64'(rd_data), 64'(0));
        chk({tag, "_err"},  64'(err_timeout), 64'(0));
    endtask

    // Entered in an IDLE cycle with inputs already applied. Completes with
    // mem_ack_vld on BUSY cycle 'delay' (0-based) or times out on cycle TMO-1.
    task automatic txn(input int delay, input bit keep, input bit drop_mid,
                       input logic [63:0] rdv, output int obs_g);
        int g;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic ewe, ere, fin;
        obs_g = -1;
        #1;
        idle_checks("idle");
        g = pick(req_vld);
        if (g < 0) begin
            tick();
            mem_ack_vld = 1'b0;
            return;
        end
        ea  = addr[g*AW +: AW];
        ed  = wr_data[g*DW +: DW];
        ewe = wr_en[g];
        ere = rd_en[g];
        tick();
        ptr_m = (g + 1) % N;
        for (int c = 0; c < TMO; c++) begin
            mem_ack_vld = (c == delay);
            mem_rd_data = (c == delay) ? rdv : 64'($urandom);
            if (drop_mid && c == 1) req_vld[g] = 1'b0;
            if (c == 0 && $urandom_range(0, 3) == 0) begin
                addr[g*AW +: AW]    = $urandom;
                wr_data[g*DW +: DW] = {$urandom, $urandom};
            end
            #1;
            if (c == 0) obs_g = int'(grant_id);
            chk("busy",   64'(busy), 64'(1));
            chk("mreq",   64'(mem_req_vld), 64'(1));
            chk("gid",    64'(grant_id), 64'(g));
            chk("maddr",  64'(mem_addr), 64'(ea));
            chk("mwdata", 64'(mem_wr_data), 64'(ed));
            chk("mwe",    64'(mem_wr_en), 64'(ewe));
            chk("mre",    64'(mem_rd_en), 64'(ere));
            fin = 1'b1;
            if (c == delay) begin
                chk("ack",      64'(ack_vld), 64'(1 << g));
                chk("rdata",    64'(rd_data), rdv);
                chk("err_none", 64'(err_timeout), 64'(0));
            end else if (c == TMO - 1) begin
                chk("tmo_ack",  64'(ack_vld), 64'(1 << g));
                chk("tmo_rd",   64'(rd_data), '1);
                chk("tmo_err",  64'(err_timeout), 64'(1));
            end else begin
                chk("wait_ack", 64'(ack_vld), 64'(0));
                chk("wait_rd",  64'(rd_data), 64'(0));
                chk("wait_err", 64'(err_timeout), 64'(0));
                fin = 1'b0;
            end
            if (fin) break;
            tick();
        end
        tick();
        mem_ack_vld = 1'b0;
        if (!keep) req_vld[g] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ptr_m = 0;
        tick();
    endtask

    initial begin
        int gobs;
        int order [5] = '{0, 1, 2, 3, 0};

        // Reset: outputs low even with requests pending.
        req_vld = '1;
        tick();
        tick();
        #1;
        idle_checks("rst");
        chk("rst_gid", 64'(grant_id), 64'(0));
        req_vld = '0;
        rst = 1'b0;
        tick();

        // Single read from requester 2.
        req_vld[2] = 1'b1;
        rd_en[2]   = 1'b1;
        addr[2*AW +: AW] = 32'h100;
        txn(3, 1'b0, 1'b0, 64'hDEAD_BEEF, gobs);
        chk("read_gid", 64'(gobs), 64'(2));
        rd_en = '0;

        // Write, requester drops req_vld mid-transaction.
        req_vld[1] = 1'b1;
        wr_en[1]   = 1'b1;
        wr_data[1*DW +: DW] = 64'h1234;
        txn(4, 1'b0, 1'b1, 64'h55, gobs);
        chk("write_gid", 64'(gobs), 64'(1));
        wr_en = '0;

        // Fairness with all requests held.
        do_reset();
        req_vld = '1;
        for (int k = 0; k < 5; k++) begin
            txn(k, 1'b1, 1'b0, {$urandom, $urandom}, gobs);
            chk("fair_order", 64'(gobs), 64'(order[k]));
        end
        req_vld = '0;
        tick();

        // Timeout, then ack colliding with the timeout cycle.
        req_vld[3] = 1'b1;
        txn(99, 1'b0, 1'b0, 64'h0, gobs);
        req_vld[0] = 1'b1;
        txn(TMO - 1, 1'b0, 1'b0, 64'hCAFE_F00D, gobs);

        // Reset mid-BUSY, then a stray mem_ack_vld.
        req_vld[0] = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rstb_ack", 64'(ack_vld), 64'(0));
        chk("rstb_err", 64'(err_timeout), 64'(0));
        tick();
        rst = 1'b0;
        req_vld = '0;
        ptr_m = 0;
        #1;
        idle_checks("post_rst");
        mem_ack_vld = 1'b1;
        mem_rd_data = 64'h77;
        tick();
        #1;
        idle_checks("stray_ack");
        mem_ack_vld = 1'b0;
        tick();

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_vld[i] && $urandom_range(0, 1) == 1) begin
                    req_vld[i] = 1'b1;
                    wr_en[i]   = 1'($urandom);
                    rd_en[i]   = 1'($urandom);
                    addr[i*AW +: AW]    = $urandom;
                    wr_data[i*DW +: DW] = {$urandom, $urandom};
                end
            end
            mem_ack_vld = 1'($urandom_range(0, 1));
            txn($urandom_range(0, 9), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                {$urandom, $urandom}, gobs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter REQ_CNT, default 4, number of upstream requesters (2..16).
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 32, memory address width.
REQ-003 SHALL have parameter MEM_DATA_WIDTH, default 64, memory data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, max wait for mem_ack_vld (0 = timeout disabled).
REQ-005 SHALL have ports:
- clk  input  1  clock; one clock domain, all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_vld  input  REQ_CNT  per-requester request, held until its ack.
- wr_en  input  REQ_CNT  per-requester write.
- rd_en  input  REQ_CNT  per-requester read.
- addr  input  REQ_CNT*MEM_ADDR_WIDTH  packed addresses, requester i at slice i.
- wr_data  input  REQ_CNT*MEM_DATA_WIDTH  packed write data.
- ack_vld  output  REQ_CNT  one-hot completion pulse.
- rd_data  output  MEM_DATA_WIDTH  read data, shared by all requesters.
- mem_req_vld  output  1  downstream request.
- mem_ack_vld  input  1  downstream completion.
- mem_addr  output  MEM_ADDR_WIDTH  downstream address.
- mem_wr_en  output  1  downstream write.
- mem_rd_en  output  1  downstream read.
- mem_wr_data  output  MEM_DATA_WIDTH  downstream write data.
- mem_rd_data  input  MEM_DATA_WIDTH  downstream read data.
- grant_id  output  log2(REQ_CNT)  index of the current owner.
- busy  output  1  transaction in flight.
- err_timeout  output  1  one-cycle pulse on timeout.

Function
REQ-006 SHALL implement states IDLE and BUSY.
REQ-007 IDLE: if any req_vld is high, SHALL pick a winner by round-robin from pointer ptr, register the winner's addr, wr_en, rd_en and wr_data plus grant_id, and enter BUSY next cycle; otherwise stay in IDLE.
REQ-008 Round-robin: search order ptr, ptr+1, ... mod REQ_CNT; after a grant to g, ptr becomes (g+1) mod REQ_CNT; ptr is 0 after reset.
REQ-009 BUSY: mem_req_vld=1, and mem_addr/mem_wr_en/mem_rd_en/mem_wr_data SHALL be driven from registered payload, stable for the whole of BUSY.
REQ-010 When mem_ack_vld=1 in BUSY: ack_vld[grant_id]=1 and rd_data=mem_rd_data in the same cycle (combinational); next state IDLE.
REQ-011 Earliest latency: req_vld at cycle N, mem_req_vld at N+1, ack_vld no earlier than N+1.
REQ-012 A requester SHALL drop req_vld the cycle after its ack; a new grant SHALL be evaluated in that IDLE cycle (one idle cycle minimum between transactions).
REQ-013 Timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-014 If the count reaches TIMEOUT_CYCLES-1 without mem_ack_vld: ack_vld[grant_id]=1, rd_data all-ones, err_timeout=1 that cycle, next state IDLE.
REQ-015 If mem_ack_vld and timeout occur in the same cycle, mem_ack_vld SHALL win: no err_timeout, real data returned.
REQ-016 mem_ack_vld in IDLE SHALL be ignored; ack_vld stays 0.
REQ-017 Outside an ack cycle: ack_vld=0 and rd_data=0.
REQ-018 wr_en and rd_en SHALL be forwarded unchecked.
REQ-019 busy SHALL equal (state==BUSY); grant_id SHALL hold the last winner.
REQ-020 req_vld changes during BUSY SHALL not affect the current transaction.

Reset
REQ-021 rst SHALL force state IDLE, ptr=0, grant_id=0, counter=0 and payload registers=0 at the next edge.
REQ-022 In reset, all outputs SHALL be 0.
REQ-023 rst during BUSY SHALL abandon the transaction with no ack and no err_timeout; a late mem_ack_vld is ignored per REQ-016.

Structure
REQ-024 Package mem_arb_pkg SHALL hold the state enum and the timeout read-data constant (all-ones).
REQ-025 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req and ptr; outputs one-hot grant and index).
REQ-026 Payload selection SHALL reuse the existing one_hot_mux.
REQ-027 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-028 Single read: req_vld[2]=1, addr=0x100; mem_ack_vld 3 cycles after mem_req_vld with mem_rd_data=0xDEADBEEF -> mem_addr=0x100, ack_vld=4'b0100, rd_data=0xDEADBEEF.
REQ-029 Fairness: all four req_vld held high continuously -> grant order 0,1,2,3,0; each ack one-hot.
REQ-030 Timeout: TIMEOUT_CYCLES=8, no mem_ack_vld -> ack_vld and err_timeout on the 8th BUSY cycle, rd_data all-ones, then IDLE.
REQ-031 Collision: mem_ack_vld on the timeout cycle -> err_timeout=0, rd_data=mem_rd_data.
REQ-032 Reset mid-BUSY: rst at BUSY cycle 2 -> mem_req_vld=0 next cycle, no ack; a mem_ack_vld after reset produces no ack.
REQ-033 Write: req_vld[1]=1, wr_en=1, wr_data=0x1234; req_vld[1] deasserted during BUSY -> mem_wr_data=0x1234 held until ack; ack_vld[1] still asserted.
